axi_slave_mem_responder: RTL



---
 rtl/axi_slave_pkg.sv | 27 ++
 rtl/axi_slave_mem.sv | 31 +++
 rtl/axi_slave_mem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_pkg.sv
// Shared encodings and address helpers for the AXI4 slave memory responder.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Only INCR advances; FIXED holds, and WRAP is served as FIXED.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_INCR) ? addr + (64'd1 << size) : addr;
    endfunction

    function automatic logic burst_err(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [2:0] max_size);
        return (burst == BURST_WRAP) || (size > max_size);
    endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Word-organised scratch memory: one byte-enable write port, one combinational read port.
module axi_slave_mem #(
    parameter  int DEPTH      = 256,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int BYTES      = DATA_WIDTH / 8
) (
    input  logic                  sig_clock,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would turn RAM into flops and its contents are undefined after power-up anyway.
    always_ff @(posedge sig_clock) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // A same-edge reader samples this before the write lands, giving read-before-write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave terminating AW/W/B/AR/R on a small register memory.
// Optional LFSR backpressure: define AXI_SLAVE_BACKPRESSURE_EN.
module axi_slave_mem_responder
    import axi_slave_pkg::*;
#(
    parameter int          ID_WIDTH   = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_DEPTH  = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    sig_clock,
    input  logic                    sig_reset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int         BYTES       = DATA_WIDTH / 8;
    localparam int         OFFSET_BITS = $clog2(BYTES);
    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE    = 3'(OFFSET_BITS);

    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128) begin : g_bad_width
        $error("DATA_WIDTH must be 32, 64 or 128");
    end

    logic stall;

`ifdef AXI_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Galois form, taps 16,14,13,11.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) lfsr <= LFSR_SEED;
        else           lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ---------------- write channel ----------------
    wr_state_t             w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [7:0]            w_len;
    logic [7:0]            w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  w_oor;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic                  awready_q;
    logic                  wready_q;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  mem_we;

    assign awready     = awready_q & ~stall;
    assign wready      = wready_q & ~stall;
    assign aw_fire     = awvalid & awready;
    assign w_fire      = wvalid & wready;
    assign w_word      = w_addr >> OFFSET_BITS;
    assign w_oor       = (w_word >= ADDR_WIDTH'(MEM_DEPTH));
    assign w_last_beat = (w_beat == w_len);
    // The burst length comes from awlen; a wlast disagreeing with it only flags an error.
    assign w_beat_err  = w_oor | (wlast != w_last_beat);
    assign mem_we      = w_fire & ~w_oor;

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= RESP_OKAY;
            w_addr    <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_size    <= '0;
            w_burst   <= BURST_FIXED;
            w_err     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_fire) begin
                        bid       <= awid;
                        w_addr    <= awaddr;
                        w_len     <= awlen;
                        w_size    <= awsize;
                        w_burst   <= awburst;
                        w_beat    <= '0;
                        w_err     <= burst_err(awburst, awsize, MAX_SIZE);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_beat <= w_beat + 8'd1;
                        w_addr <= ADDR_WIDTH'(next_addr(64'(w_addr), w_size, w_burst));
                        w_err  <= w_err | w_beat_err;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid   <= 1'b1;
                            bresp    <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_cfg_err;
    logic                  r_oor;
    logic                  arready_q;
    logic                  ar_fire;
    logic                  r_fire;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] r_beat_data;

    assign arready     = arready_q & ~stall;
    assign ar_fire     = arvalid & arready;
    assign r_fire      = rvalid & rready;
    // The single read port serves the first beat from araddr and later beats from the stepped address.
    assign r_src_addr  = (r_state == R_IDLE) ? araddr
                                             : ADDR_WIDTH'(next_addr(64'(r_addr), r_size, r_burst));
    assign r_word      = r_src_addr >> OFFSET_BITS;
    assign r_oor       = (r_word >= ADDR_WIDTH'(MEM_DEPTH));
    assign r_beat_data = r_oor ? '0 : mem_rdata;

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid    <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            rlast     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_size    <= '0;
            r_burst   <= BURST_FIXED;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        rid       <= arid;
                        r_addr    <= r_src_addr;
                        r_len     <= arlen;
                        r_size    <= arsize;
                        r_burst   <= arburst;
                        r_beat    <= '0;
                        r_cfg_err <= burst_err(arburst, arsize, MAX_SIZE);
                        rdata     <= r_beat_data;
                        rresp     <= (r_oor | burst_err(arburst, arsize, MAX_SIZE)) ? RESP_SLVERR : RESP_OKAY;
                        rlast     <= (arlen == 8'd0);
                        rvalid    <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= r_src_addr;
                            rdata  <= r_beat_data;
                            rresp  <= (r_oor | r_cfg_err) ? RESP_SLVERR : RESP_OKAY;
                            rlast  <= ((r_beat + 8'd1) == r_len);
                            rvalid <= ~stall;
                        end
                    end else if (!rvalid && !stall) begin
                        rvalid <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_slave_mem #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .sig_clock (sig_clock),
        .we        (mem_we),
        .waddr     (w_word[IDX_W-1:0]),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .raddr     (r_word[IDX_W-1:0]),
        .rdata     (mem_rdata)
    );

endmodule
